lsu_ctrl: RTL and testbench

Load/store unit controller between the decode stage's memory-op outputs and the data-memory bus. It accepts one load or store at a time and checks alignment. It drives a valid/ready request to memory with byte strobes and lane-shifted store data, and waits for the memory response with a timeout. It returns a sign- or zero-extended load result, or a store acknowledgement, with the destination register tagged.

---
 rtl/lsu_ctrl_if.sv | 45 ++++
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Load/store controller signal bundle.
// Groups the decode-side request channel, the data-memory bus channel and the
// result channel.
//   master : the lsu_ctrl side. It accepts requests, drives the memory bus and
//            returns results.
//   slave  : the environment side, meaning the decode stage and the memory.
interface lsu_ctrl_if;
  // decode -> controller
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  // controller <-> memory
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic        bus_rsp_err;
  logic [63:0] bus_rdata;
  // controller -> writeback
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [63:0] resp_data;
  logic        resp_err;

  modport master (
    input  req_valid, req_we, req_func3, req_addr, req_wdata, req_rd,
    input  bus_ready, bus_rsp_valid, bus_rsp_err, bus_rdata,
    output req_ready, bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    output resp_valid, resp_rd, resp_data, resp_err
  );

  modport slave (
    output req_valid, req_we, req_func3, req_addr, req_wdata, req_rd,
    output bus_ready, bus_rsp_valid, bus_rsp_err, bus_rdata,
    input  req_ready, bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
    input  resp_valid, resp_rd, resp_data, resp_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller.
// Accepts one memory op at a time and rejects illegal or misaligned ops
// without touching the bus. Good ops get a valid/ready bus request with byte
// strobes and a lane-shifted store data word. The controller then waits for
// the response, bounded by TIMEOUT_CYCLES, and returns an extended load
// result or a store acknowledgement.
// Ports:
//   clk, rst : clock and asynchronous active-low reset.
//   lsu      : lsu_ctrl_if.master, carrying the request, bus and result
//              channels.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic      clk,
  input  logic      rst,
  lsu_ctrl_if.master lsu
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  localparam logic [15:0] LastCnt = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  func3_q, func3_d;
  logic [2:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        bus_we_q, bus_we_d;
  logic [63:0] bus_addr_q, bus_addr_d;
  logic [63:0] bus_wdata_q, bus_wdata_d;
  logic [7:0]  bus_wstrb_q, bus_wstrb_d;
  logic [15:0] cnt_q, cnt_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        illegal, misaligned;
  logic [7:0]  strb_base;
  logic [63:0] shifted, load_data;

  // Decode of the op currently presented on the request channel.
  always_comb begin
    illegal    = lsu.req_we ? lsu.req_func3[2] : (lsu.req_func3 == 3'b111);
    misaligned = 1'b0;
    strb_base  = 8'h01;
    unique case (lsu.req_func3[1:0])
      2'b00: strb_base = 8'h01;
      2'b01: begin strb_base = 8'h03; misaligned = lsu.req_addr[0];       end
      2'b10: begin strb_base = 8'h0F; misaligned = |lsu.req_addr[1:0];    end
      default: begin strb_base = 8'hFF; misaligned = |lsu.req_addr[2:0];  end
    endcase
  end

  // Extraction of load data from the aligned 8-byte beat.
  always_comb begin
    shifted = lsu.bus_rdata >> {off_q, 3'b000};
    unique case (func3_q)
      3'b000:  load_data = {{56{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  load_data = {56'd0, shifted[7:0]};
      3'b101:  load_data = {48'd0, shifted[15:0]};
      3'b110:  load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    func3_d     = func3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (lsu.req_valid) begin
          we_d        = lsu.req_we;
          func3_d     = lsu.req_func3;
          off_d       = lsu.req_addr[2:0];
          rd_d        = lsu.req_we ? 5'd0 : lsu.req_rd;
          resp_data_d = 64'd0;
          if (illegal || misaligned) begin
            resp_err_d = 1'b1;
            state_d    = StResp;
          end else begin
            resp_err_d  = 1'b0;
            bus_we_d    = lsu.req_we;
            bus_addr_d  = {lsu.req_addr[63:3], 3'b000};
            bus_wdata_d = lsu.req_we ? (lsu.req_wdata << {lsu.req_addr[2:0], 3'b000}) : 64'd0;
            bus_wstrb_d = lsu.req_we ? (strb_base << lsu.req_addr[2:0]) : 8'd0;
            state_d     = StReq;
          end
        end
      end
      StReq: begin
        if (lsu.bus_ready) begin
          cnt_d   = 16'd0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A response on the final counted cycle beats the timeout.
        if (lsu.bus_rsp_valid) begin
          resp_err_d  = lsu.bus_rsp_err;
          resp_data_d = (lsu.bus_rsp_err || we_q) ? 64'd0 : load_data;
          state_d     = StResp;
        end else if (cnt_q == LastCnt) begin
          resp_err_d  = 1'b1;
          resp_data_d = 64'd0;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      func3_q     <= 3'd0;
      off_q       <= 3'd0;
      rd_q        <= 5'd0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 64'd0;
      bus_wdata_q <= 64'd0;
      bus_wstrb_q <= 8'd0;
      cnt_q       <= 16'd0;
      resp_data_q <= 64'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  logic in_resp;
  assign in_resp        = (state_q == StResp);
  assign lsu.req_ready  = (state_q == StIdle);
  assign lsu.bus_valid  = (state_q == StReq);
  assign lsu.bus_we     = bus_we_q;
  assign lsu.bus_addr   = bus_addr_q;
  assign lsu.bus_wdata  = bus_wdata_q;
  assign lsu.bus_wstrb  = bus_wstrb_q;
  // Result fields are only meaningful alongside the one-cycle valid pulse.
  assign lsu.resp_valid = in_resp;
  assign lsu.resp_rd    = in_resp ? rd_q : 5'd0;
  assign lsu.resp_data  = in_resp ? resp_data_q : 64'd0;
  assign lsu.resp_err   = in_resp & resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized ops
// compared against a behavioural model of the access rules.
module tb_lsu_ctrl;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  lsu_ctrl_if bif ();

  lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (bif.master)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: access legality, bus lane/strobe and load value.
  function automatic void ref_model(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                                    input logic [63:0] wdata, input logic [63:0] rdata,
                                    output logic bad, output logic [7:0] strb,
                                    output logic [63:0] lane, output logic [63:0] ldata);
    int size;
    int off;
    logic [63:0] v;
    logic [63:0] mask;
    size = 1 << f3[1:0];
    off  = int'(addr[2:0]);
    bad  = (we && f3 >= 3'd4) || (!we && f3 == 3'd7) || ((addr % 64'(size)) != 64'd0);
    strb = we ? 8'(((1 << size) - 1) << off) : 8'd0;
    lane = we ? (wdata << (8 * off)) : 64'd0;
    v = rdata >> (8 * off);
    if (size < 8) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
    end
    ldata = v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ".req_ready"}, 64'(bif.req_ready), 64'd1);
    check({tag, ".bus_valid"}, 64'(bif.bus_valid), 64'd0);
    check({tag, ".bus_we"}, 64'(bif.bus_we), 64'd0);
    check({tag, ".bus_addr"}, bif.bus_addr, 64'd0);
    check({tag, ".bus_wdata"}, bif.bus_wdata, 64'd0);
    check({tag, ".bus_wstrb"}, 64'(bif.bus_wstrb), 64'd0);
    check({tag, ".resp_valid"}, 64'(bif.resp_valid), 64'd0);
    check({tag, ".resp_rd"}, 64'(bif.resp_rd), 64'd0);
    check({tag, ".resp_data"}, bif.resp_data, 64'd0);
    check({tag, ".resp_err"}, 64'(bif.resp_err), 64'd0);
  endtask

  // One access from IDLE. rsp_dly is the WAIT cycle index (0-based) carrying
  // the response; values >= T mean the memory never answers in time.
  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                       input int rdy_dly, input int rsp_dly, input logic rerr,
                       input logic [63:0] rdata);
    logic bad;
    logic [7:0] strb;
    logic [63:0] lane, ldata, exp_data;
    logic exp_err;
    int lat, exp_lat, wcnt;
    bit took;
    ref_model(we, f3, addr, wdata, rdata, bad, strb, lane, ldata);
    check({tag, ".ready"}, 64'(bif.req_ready), 64'd1);
    bif.req_valid = 1'b1;
    bif.req_we    = we;
    bif.req_func3 = f3;
    bif.req_addr  = addr;
    bif.req_wdata = wdata;
    bif.req_rd    = rd;
    tick();
    lat = 1;
    // req_valid stays high until the result, so any extra acceptance shows.
    if (bad) begin
      check({tag, ".nobus"}, 64'(bif.bus_valid), 64'd0);
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        check({tag, ".bus_valid"}, 64'(bif.bus_valid), 64'd1);
        check({tag, ".bus_we"}, 64'(bif.bus_we), 64'(we));
        check({tag, ".bus_addr"}, bif.bus_addr, {addr[63:3], 3'b000});
        check({tag, ".bus_wstrb"}, 64'(bif.bus_wstrb), 64'(strb));
        check({tag, ".bus_wdata"}, bif.bus_wdata, lane);
        bif.bus_ready     = (i == rdy_dly);
        bif.bus_rsp_valid = 1'($urandom_range(0, 1));
        bif.bus_rsp_err   = 1'($urandom_range(0, 1));
        bif.bus_rdata     = {$urandom, $urandom};
        tick();
        lat++;
      end
      bif.bus_ready     = 1'b0;
      bif.bus_rsp_valid = 1'b0;
      wcnt = 0;
      while (!bif.resp_valid && wcnt < T + 4) begin
        check({tag, ".wait_nobus"}, 64'(bif.bus_valid), 64'd0);
        bif.bus_rsp_valid = (wcnt == rsp_dly);
        bif.bus_rsp_err   = rerr;
        bif.bus_rdata     = (wcnt == rsp_dly) ? rdata : {$urandom, $urandom};
        tick();
        lat++;
        wcnt++;
      end
      bif.bus_rsp_valid = 1'b0;
    end
    took     = !bad && rsp_dly < T;
    exp_err  = took ? rerr : 1'b1;
    exp_data = (exp_err || we) ? 64'd0 : ldata;
    exp_lat  = bad ? 1 : (2 + rdy_dly + (took ? rsp_dly + 1 : T));
    check({tag, ".resp_valid"}, 64'(bif.resp_valid), 64'd1);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".resp_err"}, 64'(bif.resp_err), 64'(exp_err));
    check({tag, ".resp_data"}, bif.resp_data, exp_data);
    check({tag, ".resp_rd"}, 64'(bif.resp_rd), we ? 64'd0 : 64'(rd));
    bif.req_valid = 1'b0;
    tick();
    check({tag, ".pulse_end"}, 64'(bif.resp_valid), 64'd0);
    check({tag, ".back_idle"}, 64'(bif.req_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_func3 = 3'd0;
    bif.req_addr = 64'd0; bif.req_wdata = 64'd0; bif.req_rd = 5'd0;
    bif.bus_ready = 1'b0; bif.bus_rsp_valid = 1'b1; bif.bus_rsp_err = 1'b0;
    bif.bus_rdata = 64'd0;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    // Stale response right after reset must be ignored.
    tick();
    check("stale_rsp", 64'(bif.resp_valid), 64'd0);
    tick();
    check("stale_rsp2", 64'(bif.resp_valid), 64'd0);
    bif.bus_rsp_valid = 1'b0;

    do_op("lb_sext", 1'b0, 3'b000, 64'h1003, 64'd0, 5'd7, 0, 0, 1'b0,
          64'h0000_0000_8000_0000);
    do_op("sh_lane", 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd9, 0, 1, 1'b0, 64'd0);
    do_op("lw_misal", 1'b0, 3'b010, 64'h3002, 64'd0, 5'd3, 0, 0, 1'b0, 64'd0);
    do_op("lwu_held", 1'b0, 3'b110, 64'h4004, 64'd0, 5'd12, 5, 2, 1'b0,
          64'hFFFF_FFFF_0000_0000);
    do_op("timeout", 1'b0, 3'b011, 64'h5000, 64'd0, 5'd4, 0, 99, 1'b0, 64'h1234);
    do_op("rsp_at_limit", 1'b0, 3'b011, 64'h5008, 64'd0, 5'd5, 1, T - 1, 1'b0,
          64'h0123_4567_89AB_CDEF);
    do_op("bus_err", 1'b0, 3'b001, 64'h6002, 64'd0, 5'd6, 0, 1, 1'b1, 64'hFFFF_FFFF);
    do_op("sd_full", 1'b1, 3'b011, 64'h7000, 64'hDEAD_BEEF_CAFE_F00D, 5'd1, 2, 0, 1'b0, 64'd0);
    do_op("ill_store", 1'b1, 3'b100, 64'h8000, 64'h55, 5'd2, 0, 0, 1'b0, 64'd0);
    do_op("ill_load", 1'b0, 3'b111, 64'h8000, 64'd0, 5'd8, 0, 0, 1'b0, 64'd0);

    // Reset during WAIT aborts the access without a result.
    bif.req_valid = 1'b1; bif.req_we = 1'b0; bif.req_func3 = 3'b010;
    bif.req_addr = 64'h9004; bif.req_rd = 5'd11;
    tick();
    bif.req_valid = 1'b0;
    bif.bus_ready = 1'b1;
    tick();
    bif.bus_ready = 1'b0;
    check("mid_rst.in_wait", 64'(bif.bus_valid), 64'd0);
    rst = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    bif.bus_rsp_valid = 1'b1;
    bif.bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rsp", 64'(bif.resp_valid), 64'd0);
    end
    bif.bus_rsp_valid = 1'b0;
    do_op("after_rst", 1'b0, 3'b000, 64'hA001, 64'd0, 5'd13, 0, 0, 1'b0,
          64'h0000_0000_0000_7F00);

    for (int n = 0; n < 60; n++) begin
      logic we;
      logic [2:0] f3;
      logic [63:0] addr;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
      do_op("rand", we, f3, addr, {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 3),
            $urandom_range(0, T + 1), 1'($urandom_range(0, 7) == 0), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
